mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide responder for the EX stage. It accepts a `start` pulse and the 2-bit `ALU2Op` code that the decode control unit issues for MULT/MULTU/DIV/DIVU. It computes the 64-bit product, or the quotient and remainder, and delivers HI/LO with a one-cycle `done` pulse. The pipeline stalls on `busy` and writes the HI/LO register file on `done`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `ALU2Op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A`  in  32  rs operand (dividend / multiplicand).
- `B`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  exception/eret cancel; aborts the in-flight operation.
- `busy`  out  1  operation in progress; the pipeline must stall.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `hi`  out  32  product[63:32], or remainder.
- `lo`  out  32  product[31:0], or quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations.
  - FIX: sign correction and write.
  - DONE: `done` high for one cycle, then return to IDLE.
- IDLE with `start`=1 and `flush`=0:
  - Latch the operation.
  - For signed ops, latch |A|, |B|, sign(A) and sign(A)^sign(B); for unsigned ops latch the raw operands.
  - Clear iteration counter `cnt` (6 bits) and go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC exits to FIX when `cnt`==31 at the active edge.
- FIX:
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if sign(A)=1.
  - Register the results into `hi`/`lo`, then go to DONE.
- Divide by zero (B==0 sampled at start): skip CALC and go straight to FIX.
  - Fixed result: `lo`=0xFFFFFFFF and `hi`=A (the raw operand), for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. No trap is raised.
- `hi`/`lo` hold their value between operations and change only in FIX.
- `start` while not in IDLE is ignored; there is no queueing.
- `flush`=1 in any state:
  - Next state is IDLE; `busy`=0 and `done`=0 next cycle.
  - `hi`/`lo` are unchanged.
  - `flush` takes priority over `start` in the same cycle.
- `rst`=1, including mid-operation: state IDLE, `cnt`=0, and `busy`, `done`, `hi`, `lo` all 0 next cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0x00000000, `lo`=0x00000000.
- `busy` is high in CALC and FIX, and low in IDLE and DONE.
- `busy` rises in the cycle after the `start` edge, with no combinational path from `start`.
- Iterative path:
  - `start` sampled at edge E0.
  - CALC runs edges E1–E32; FIX at E33.
  - `done`=1 in the cycle after E33: 34 cycles from `start` to `done`.
- Divide-by-zero path: FIX at E1, `done` after E1.
- A new `start` may be sampled on the edge that ends DONE. It is accepted one cycle later, because DONE always returns to IDLE first.
- All outputs are registered; no output depends combinationally on any input.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle `*` on the sign-corrected magnitudes and go IDLE→FIX directly.
  - `done` follows 2 edges after `start`.
- `MDU_FAST_MUL_EN` undefined: multiplication uses the 32-cycle shift-add path.
- Division is iterative in both builds.
- Results and the `busy`/`flush` rules are identical in both builds.

## Test plan
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` 34 cycles after `start` (2 with `MDU_FAST_MUL_EN`).
- MULT, A=0xFFFFFFFE (-2), B=0x00000003 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (-7), B=2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1); DIVU, A=100, B=7 → `lo`=14, `hi`=2.
- DIVU, A=0x12345678, B=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678, `done` 2 cycles after `start`, `busy` high for exactly 1 cycle.
- DIV in progress, `flush` at iteration 10 → `busy`=0 next cycle, no `done`, `hi`/`lo` keep their previous values; a new MULTU started 1 cycle later completes correctly.
- `start` pulsed while `busy` → ignored, first result unchanged; `rst` mid-CALC → all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO with a
//               one-cycle done pulse. Define MDU_FAST_MUL_EN for a
//               single-cycle multiply; division stays iterative.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALU2Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0]         c_LAST = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE  = 1;
    localparam logic [2*WIDTH-1:0] c_ONE2 = 1;

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_cnt;
    logic               r_is_div;
    logic               r_dz;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_div_op;
    logic               w_dz_in;
    logic               w_fast;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ALU2Op[0];
    assign w_div_op = ALU2Op[1];
    assign w_dz_in  = w_div_op && (B == '0);
    assign w_mag_a  = (w_signed && A[WIDTH-1]) ? (~A + c_ONE) : A;
    assign w_mag_b  = (w_signed && B[WIDTH-1]) ? (~B + c_ONE) : B;

`ifdef MDU_FAST_MUL_EN
    assign w_fast = ~w_div_op;
`else
    assign w_fast = 1'b0;
`endif

    // Shift-add: r_acc holds {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // Restoring divide: r_acc[WIDTH-1:0] shifts dividend out and quotient in.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

    assign w_prod = r_sign_q ? (~r_acc + c_ONE2) : r_acc;
    assign w_quo  = r_sign_q ? (~r_acc[WIDTH-1:0] + c_ONE) : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign_r ? (~r_rem + c_ONE) : r_rem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (w_dz_in || w_fast) ? FIX : CALC;
            CALC:    if (r_cnt == c_LAST) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == CALC) || (w_next == FIX);
            r_done  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        r_is_div <= w_div_op;
                        r_dz     <= w_dz_in;
                        r_sign_q <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_sign_r <= w_signed & A[WIDTH-1];
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_opnd   <= w_div_op ? w_mag_b : w_mag_a;
                        if (w_dz_in)
                            r_acc <= {{WIDTH{1'b0}}, A};
                        else if (w_fast)
                            r_acc <= {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
                        else
                            r_acc <= {{WIDTH{1'b0}}, (w_div_op ? w_mag_a : w_mag_b)};
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_is_div) begin
                            r_rem              <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (r_dz) begin
                            r_hi <= r_acc[WIDTH-1:0];
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ALU2Op (op),
        .A      (a),
        .B      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat counts rising edges from the start edge up to the one that raised done
    task automatic wait_done(output int lat, output int busyc, output logic seen);
        lat   = 1;
        busyc = 0;
        seen  = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (busy) busyc++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] want_hi, input logic [31:0] want_lo,
                          input int want_lat, input int want_busy);
        int   lat;
        int   busyc;
        logic seen;
        launch(o, x, y);
        wait_done(lat, busyc, seen);
        check({tag, " done"}, 64'(seen), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(want_hi));
        check({tag, " lo"}, 64'(lo), 64'(want_lo));
        check({tag, " latency"}, 64'(lat), 64'(want_lat));
        check({tag, " busy cycles"}, 64'(busyc), 64'(want_busy));
        exp_hi = want_hi;
        exp_lo = want_lo;
        @(negedge clk);
        check({tag, " busy/done after"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int   lat;
        int   busyc;
        logic seen;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        run_op("multu_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, MUL_BUSY);
        run_op("mult_neg",   2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT, MUL_BUSY);
        run_op("mult_posneg",2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, MUL_BUSY);
        run_op("div_neg",    2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
        run_op("divu",       2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       34, 33);
        run_op("div_posneg", 2'b11, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 34, 33);
        run_op("div_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33);
        run_op("divu_zero",  2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 2, 1);
        run_op("div_zero",   2'b11, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 2, 1);

        // Flush a divide at iteration 10; results must hold, then a multiply runs cleanly.
        launch(2'b11, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi held", 64'(hi), 64'(exp_hi));
        check("flush lo held", 64'(lo), 64'(exp_lo));
        run_op("multu_after_flush", 2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT, MUL_BUSY);

        // A second start during CALC must be ignored.
        launch(2'b10, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1 begin op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, busyc, seen);
        check("ignored start done", 64'(seen), 64'd1);
        check("ignored start hi", 64'(hi), 64'd2);
        check("ignored start lo", 64'(lo), 64'd14);
        @(negedge clk);
        check("ignored start after", 64'({busy, done}), 64'd0);

        // Reset in the middle of CALC clears everything.
        launch(2'b00, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        run_op("multu_after_rst", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, MUL_LAT, MUL_BUSY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
